seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 51 +++++
 rtl/seg7_hex_decode.sv | 39 +++
 rtl/seg_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants and types for the 8-digit multiplexed 7-segment scanner.
//   - NUM_DIGITS / DIGIT_W : digit count and digit index width
//   - SEG_HEX_0..SEG_HEX_F : segment patterns (gfedcba, active-high)
//   - SEG_OFF / SEL_NONE   : blanked segment and digit-select values
//   - phase_t              : per-slot phase (blanking, then showing)
//   - sel_one_cold()       : active-low one-cold digit select for an index
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 3;
    localparam int HEX_W      = 4;
    localparam int SEG_W      = 7;

    localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

    localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_HEX_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_HEX_B = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_HEX_C = 7'h39;
    localparam logic [SEG_W-1:0] SEG_HEX_D = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_HEX_E = 7'h79;
    localparam logic [SEG_W-1:0] SEG_HEX_F = 7'h71;

    localparam logic [SEG_W-1:0]      SEG_OFF  = 7'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_NONE = 8'hFF;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    function automatic logic [NUM_DIGITS-1:0] sel_one_cold(input logic [DIGIT_W-1:0] d);
        logic [NUM_DIGITS-1:0] sel;
        sel    = SEL_NONE;
        sel[d] = 1'b0;
        return sel;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Purely combinational hex digit to 7-segment (gfedcba, active-high) decoder.
//   hex : 4-bit digit value 0-F
//   seg : segment pattern
// -----------------------------------------------------------------------------
module seg7_hex_decode
    import seg_pkg::*;
(
    input  logic [HEX_W-1:0] hex,
    output logic [SEG_W-1:0] seg
);

    // NOTE: every output of an always_comb gets a default before any branch,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scanner for an 8-digit 7-segment display with a
// double-buffered digit store. Host writes land in the shadow bank; a commit
// copies shadow to the displayed (active) bank only at a frame boundary, so a
// frame never shows a half-updated value.
//
// Parameters
//   DIV   : clock cycles per digit slot (DIV > BLANK)
//   BLANK : blanking cycles at the start of each slot (BLANK >= 1)
// Ports
//   CLK            : clock, rising edge
//   RESET          : asynchronous, active-high reset
//   ENABLE         : scan enable; low parks the scan at digit 0, counter 0
//   WR_EN          : shadow write strobe
//   WR_ADDR        : shadow digit index (0 = least significant)
//   WR_DATA        : hex value to write
//   COMMIT         : request shadow -> active copy at the next frame boundary
//   LZ_SUPPRESS    : blank leading zeros (digit 0 always shown)
//   SEG_C          : segments gfedcba, active-high, registered
//   SEG_SEL        : digit select, active-low one-cold, registered
//   FRAME_DONE     : one-cycle pulse after each frame's last cycle
//   COMMIT_PENDING : a commit is latched and waiting for a boundary
// -----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
)
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic                  WR_EN,
    input  logic [DIGIT_W-1:0]    WR_ADDR,
    input  logic [HEX_W-1:0]      WR_DATA,
    input  logic                  COMMIT,
    input  logic                  LZ_SUPPRESS,
    output logic [SEG_W-1:0]      SEG_C,
    output logic [NUM_DIGITS-1:0] SEG_SEL,
    output logic                  FRAME_DONE,
    output logic                  COMMIT_PENDING
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIGIT_W-1:0] dig_q, dig_d;
    phase_t             phase_q, phase_d;
    logic               boundary;

    logic [HEX_W-1:0]   shadow [NUM_DIGITS];
    logic [HEX_W-1:0]   active [NUM_DIGITS];
    logic               pending_q;

    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  zero_from_top;
    logic [SEG_W-1:0]      dec_seg;
    logic [SEG_W-1:0]      seg_d;
    logic [NUM_DIGITS-1:0] sel_d;

    seg7_hex_decode u_decode (
        .hex (active[dig_q]),
        .seg (dec_seg)
    );

    // ------------------------------------------------------------------
    // Slot counter, digit index and frame boundary
    // ------------------------------------------------------------------
    always_comb begin
        boundary = ENABLE && (cnt_q == CNT_LAST) && (dig_q == LAST_DIGIT);
        cnt_d    = cnt_q;
        dig_d    = dig_q;
        if (!ENABLE) begin
            cnt_d = '0;
            dig_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            dig_d = dig_q + DIGIT_W'(1);   // 7 -> 0 through natural wrap
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero mask: a digit is blanked when it and every digit above it
    // are zero; digit 0 is exempt so a value of zero still shows "0".
    // ------------------------------------------------------------------
    always_comb begin
        zero_from_top = 1'b1;
        lz_blank      = '0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            zero_from_top = zero_from_top && (active[d] == '0);
            lz_blank[d]   = LZ_SUPPRESS && (d != 0) && zero_from_top;
        end
    end

    // ------------------------------------------------------------------
    // Slot phase FSM: next state from the counter value it will hold, and
    // pin values from the current state (registered below, one cycle late).
    // ------------------------------------------------------------------
    always_comb begin
        phase_d = phase_q;
        sel_d   = SEL_NONE;
        seg_d   = SEG_OFF;

        case (phase_q)
            PH_BLANK: if (cnt_d >= CNT_BLANK) phase_d = PH_SHOW;
            PH_SHOW:  if (cnt_d <  CNT_BLANK) phase_d = PH_BLANK;
            default:  phase_d = PH_BLANK;
        endcase

        // Dropping ENABLE must blank the pins on the very next edge.
        if (ENABLE && (phase_q == PH_SHOW)) begin
            sel_d = sel_one_cold(dig_q);
            seg_d = lz_blank[dig_q] ? SEG_OFF : dec_seg;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q      <= '0;
            dig_q      <= '0;
            phase_q    <= PH_BLANK;
            SEG_C      <= SEG_OFF;
            SEG_SEL    <= SEL_NONE;
            FRAME_DONE <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dig_q      <= dig_d;
            phase_q    <= phase_d;
            SEG_C      <= seg_d;
            SEG_SEL    <= sel_d;
            FRAME_DONE <= boundary;
        end
    end

    // ------------------------------------------------------------------
    // Register banks and commit handshake
    // ------------------------------------------------------------------
    // NOTE: both banks are reset explicitly because a freshly reset display
    // must show zeros; they are small flop arrays, not RAM macros.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            pending_q <= 1'b0;
        end else begin
            // The copy reads shadow before this edge's write, so a write
            // coinciding with the boundary reaches shadow only.
            if (boundary && (pending_q || COMMIT)) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    active[i] <= shadow[i];
                end
                pending_q <= 1'b0;
            end else if (COMMIT) begin
                pending_q <= 1'b1;
            end
            if (WR_EN) begin
                shadow[WR_ADDR] <= WR_DATA;
            end
        end
    end

    assign COMMIT_PENDING = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Scoreboard bench for seg_scan_ctrl with DIV=8, BLANK=2. A reference model
// tracks the scan as a single frame position (slot = pos / DIV, offset =
// pos % DIV) plus shadow/active arrays, and queues the pin values expected
// after each clock edge; a monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 8 * DIV;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       ENABLE = 1'b0;
    logic       WR_EN = 1'b0;
    logic [2:0] WR_ADDR = '0;
    logic [3:0] WR_DATA = '0;
    logic       COMMIT = 1'b0;
    logic       LZ_SUPPRESS = 1'b0;
    logic [6:0] SEG_C;
    logic [7:0] SEG_SEL;
    logic       FRAME_DONE;
    logic       COMMIT_PENDING;

    seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .ENABLE         (ENABLE),
        .WR_EN          (WR_EN),
        .WR_ADDR        (WR_ADDR),
        .WR_DATA        (WR_DATA),
        .COMMIT         (COMMIT),
        .LZ_SUPPRESS    (LZ_SUPPRESS),
        .SEG_C          (SEG_C),
        .SEG_SEL        (SEG_SEL),
        .FRAME_DONE     (FRAME_DONE),
        .COMMIT_PENDING (COMMIT_PENDING)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] sel;
        logic [6:0] seg;
        logic       fd;
        logic       pend;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    logic [6:0] hex_font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state: position in the frame the next edge will see.
    int         m_pos = 0;
    logic [3:0] m_shadow [8];
    logic [3:0] m_active [8];
    logic       m_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    always @(posedge CLK or posedge RESET) begin : model
        exp_t e;
        int   slot;
        int   off;
        bit   bnd;
        bit   all_zero;
        if (RESET) begin
            m_pos  = 0;
            m_pend = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_shadow[i] = '0;
                m_active[i] = '0;
            end
            sb_q.delete();
        end else begin
            e     = '0;
            e.sel = 8'hFF;
            bnd   = 1'b0;
            if (ENABLE) begin
                slot = m_pos / DIV;
                off  = m_pos % DIV;
                bnd  = (m_pos == FRAME - 1);
                if (off >= BLANK) begin
                    e.sel[slot] = 1'b0;
                    all_zero = 1'b1;
                    for (int j = slot; j < 8; j++)
                        if (m_active[j] != 0) all_zero = 1'b0;
                    e.seg = (LZ_SUPPRESS && slot > 0 && all_zero) ? 7'h00 : hex_font[m_active[slot]];
                end
                m_pos = (m_pos + 1) % FRAME;
            end else begin
                m_pos = 0;
            end
            e.fd = bnd;
            if (bnd && (m_pend || COMMIT)) begin
                for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
                m_pend = 1'b0;
            end else if (COMMIT) begin
                m_pend = 1'b1;
            end
            if (WR_EN) m_shadow[WR_ADDR] = WR_DATA;
            e.pend = m_pend;
            sb_q.push_back(e);
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("seg_sel",        SEG_SEL,        e.sel);
            check("seg_c",          SEG_C,          e.seg);
            check("frame_done",     FRAME_DONE,     e.fd);
            check("commit_pending", COMMIT_PENDING, e.pend);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Advance until the next edge will see frame position 'target'.
    task automatic wait_pos(input int target);
        for (int i = 0; i < 3 * FRAME && m_pos != target; i++) step();
        check("wait_pos", m_pos, target);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #1;
        check("rst_seg_sel",        SEG_SEL,        8'hFF);
        check("rst_seg_c",          SEG_C,          7'h00);
        check("rst_frame_done",     FRAME_DONE,     1'b0);
        check("rst_commit_pending", COMMIT_PENDING, 1'b0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic write_digit(input int addr, input int val);
        WR_EN   = 1'b1;
        WR_ADDR = addr[2:0];
        WR_DATA = val[3:0];
        step();
        WR_EN   = 1'b0;
    endtask

    task automatic pulse_commit();
        COMMIT = 1'b1;
        step();
        COMMIT = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        #2;
        do_reset();

        // Scan timing from reset release, two full frames.
        ENABLE = 1'b1;
        step(2 * FRAME + 4);

        // Load 1..8, commit mid-frame; display changes only after the boundary.
        for (int i = 0; i < 8; i++) write_digit(i, i + 1);
        wait_pos(3 * DIV + 3);
        pulse_commit();
        step(2 * FRAME);

        // Write digit 3 and commit on the boundary cycle itself.
        wait_pos(FRAME - 1);
        WR_EN = 1'b1; WR_ADDR = 3'd3; WR_DATA = 4'h9; COMMIT = 1'b1;
        step();
        WR_EN = 1'b0; COMMIT = 1'b0;
        step(FRAME);
        // Commit the cycle after a boundary, repeated (one copy only).
        wait_pos(0);
        pulse_commit();
        step(3);
        pulse_commit();
        pulse_commit();
        step(2 * FRAME);

        // Leading-zero suppression: digits 7..0 = 0,0,0,0,0,1,0,5.
        for (int i = 0; i < 8; i++) write_digit(i, (i == 2) ? 1 : (i == 0) ? 5 : 0);
        pulse_commit();
        LZ_SUPPRESS = 1'b1;
        step(2 * FRAME);
        LZ_SUPPRESS = 1'b0;
        step(FRAME);

        // Drop ENABLE in the SHOW phase of digit 4, then resume from digit 0.
        wait_pos(4 * DIV + 4);
        ENABLE = 1'b0;
        step(5);
        pulse_commit();
        ENABLE = 1'b1;
        step(FRAME + 4);

        // Reset with a commit pending: nothing may be copied afterwards.
        for (int i = 0; i < 8; i++) write_digit(i, 7);
        wait_pos(2 * DIV);
        pulse_commit();
        step(3);
        check("pend_before_reset", COMMIT_PENDING, 1'b1);
        do_reset();
        step(FRAME + 4);

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            WR_EN   = ($urandom_range(0, 3) == 0);
            WR_ADDR = 3'($urandom_range(0, 7));
            WR_DATA = 4'($urandom_range(0, 15));
            COMMIT  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 199) == 0) LZ_SUPPRESS = ~LZ_SUPPRESS;
            if (ENABLE) begin
                if ($urandom_range(0, 299) == 0) ENABLE = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                ENABLE = 1'b1;
            end
            step();
        end
        WR_EN  = 1'b0;
        COMMIT = 1'b0;
        step(2);

        @(negedge CLK);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
